ahb_bm_input_stage: RTL and testbench

Master-side input stage of the AHB bus matrix; the counterpart to the per-slave output arbiters. It accepts an address phase from one master and raises a request to the output stages. If the addressed output stage has not granted the port, it holds the address phase in a register and inserts wait states towards the master. It then routes the slave-side HREADY/HRESP back to the master during the data phase.

---
 rtl/ahb_bm_pkg.sv | 40 ++++
 rtl/ahb_bm_addr_hold.sv | 53 +++++
 rtl/ahb_bm_input_stage.sv | 114 +++++++++++
 tb/tb_ahb_bm_input_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_bm_pkg.sv
// Shared AHB encodings and the control bundle carried alongside HADDR
// through the bus matrix input and output stages.
package ahb_bm_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef struct packed {
        htrans_e    trans;
        logic       write;
        logic [2:0] size;
        hburst_e    burst;
        logic [3:0] prot;
        logic       lock;
    } ahb_ctrl_t;

    // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY never do.
    function automatic logic trans_is_active(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage

// File: rtl/ahb_bm_addr_hold.sv
// Address-phase hold register with a pass-through mux: live master signals
// flow straight through unless a pending transfer needs its captured copy.
module ahb_bm_addr_hold
    import ahb_bm_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  load,
    input  logic                  sel,
    input  logic                  pend,
    input  logic [ADDR_WIDTH-1:0] addr_s,
    input  ahb_ctrl_t             ctrl_s,
    output logic [ADDR_WIDTH-1:0] addr_m,
    output ahb_ctrl_t             ctrl_m
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    ahb_ctrl_t             ctrl_q, ctrl_d;

    always_comb begin
        addr_d = addr_q;
        ctrl_d = ctrl_q;
        if (load) begin
            addr_d = addr_s;
            ctrl_d = ctrl_s;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_q <= '0;
            ctrl_q <= '0;
        end else begin
            addr_q <= addr_d;
            ctrl_q <= ctrl_d;
        end
    end

    // An unselected port must not leak the master's HTRANS to the slaves.
    always_comb begin
        addr_m = addr_s;
        ctrl_m = ctrl_s;
        if (pend) begin
            addr_m = addr_q;
            ctrl_m = ctrl_q;
        end else if (!sel) begin
            ctrl_m.trans = HTRANS_IDLE;
        end
    end

endmodule

// File: rtl/ahb_bm_input_stage.sv
// Master-side input stage of the AHB bus matrix: requests the output stages,
// stalls the master while ungranted, and routes slave HREADY/HRESP back.
module ahb_bm_input_stage
    import ahb_bm_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    input  logic                  addr_grant,
    input  logic                  HREADYM,
    input  logic                  HRESPM,
    output logic                  req_port,
    output logic [ADDR_WIDTH-1:0] HADDRM,
    output logic [1:0]            HTRANSM,
    output logic                  HWRITEM,
    output logic [2:0]            HSIZEM,
    output logic [2:0]            HBURSTM,
    output logic [3:0]            HPROTM,
    output logic                  HMASTLOCKM,
    output logic                  HREADYOUTS,
    output logic                  HRESPS
);

    logic      trans_valid;
    logic      issue;
    logic      pend_tran_q, pend_tran_d;
    logic      data_active_q, data_active_d;
    ahb_ctrl_t ctrl_s, ctrl_m;

    assign trans_valid = HSELS & HREADYS & trans_is_active(HTRANSS);
    assign issue       = addr_grant & (pend_tran_q | trans_valid);

    always_comb begin
        ctrl_s.trans = htrans_e'(HTRANSS);
        ctrl_s.write = HWRITES;
        ctrl_s.size  = HSIZES;
        ctrl_s.burst = hburst_e'(HBURSTS);
        ctrl_s.prot  = HPROTS;
        ctrl_s.lock  = HMASTLOCKS;
    end

    // A transfer goes pending only when it cannot issue this very cycle.
    always_comb begin
        pend_tran_d = pend_tran_q;
        if (trans_valid && !(addr_grant && HREADYM)) begin
            pend_tran_d = 1'b1;
        end else if (pend_tran_q && addr_grant && HREADYM) begin
            pend_tran_d = 1'b0;
        end
    end

    always_comb begin
        data_active_d = data_active_q;
        if (HREADYM) begin
            data_active_d = issue;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pend_tran_q   <= 1'b0;
            data_active_q <= 1'b0;
        end else begin
            pend_tran_q   <= pend_tran_d;
            data_active_q <= data_active_d;
        end
    end

    ahb_bm_addr_hold #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_hold (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .load   (HREADYS),
        .sel    (HSELS),
        .pend   (pend_tran_q),
        .addr_s (HADDRS),
        .ctrl_s (ctrl_s),
        .addr_m (HADDRM),
        .ctrl_m (ctrl_m)
    );

    always_comb begin
        HTRANSM    = ctrl_m.trans;
        HWRITEM    = ctrl_m.write;
        HSIZEM     = ctrl_m.size;
        HBURSTM    = ctrl_m.burst;
        HPROTM     = ctrl_m.prot;
        HMASTLOCKM = ctrl_m.lock;
    end

    always_comb begin
        req_port   = trans_valid | pend_tran_q;
        HREADYOUTS = 1'b1;
        HRESPS     = HRESP_OKAY;
        if (data_active_q) begin
            HREADYOUTS = HREADYM;
            HRESPS     = HRESPM;
        end else if (pend_tran_q) begin
            HREADYOUTS = 1'b0;
        end
    end

endmodule

// File: tb/tb_ahb_bm_input_stage.sv
// Directed bench for the bus matrix input stage; HREADYS is looped back from
// HREADYOUTS as it would be on a single-slave master bus.
module tb_ahb_bm_input_stage;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'd0;
    localparam logic [2:0] B_INCR   = 3'd1;
    localparam logic [2:0] B_INCR4  = 3'd3;

    logic        HCLK, HRESET, HSELS, HWRITES, HMASTLOCKS, HREADYS;
    logic [31:0] HADDRS, HADDRM;
    logic [1:0]  HTRANSS, HTRANSM;
    logic [2:0]  HSIZES, HBURSTS, HSIZEM, HBURSTM;
    logic [3:0]  HPROTS, HPROTM;
    logic        addr_grant, HREADYM, HRESPM;
    logic        req_port, HWRITEM, HMASTLOCKM, HREADYOUTS, HRESPS;

    int n_checks = 0;
    int n_fail   = 0;

    assign HREADYS = HREADYOUTS;

    ahb_bm_input_stage #(.ADDR_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS),
        .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
        .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
        .addr_grant(addr_grant), .HREADYM(HREADYM), .HRESPM(HRESPM),
        .req_port(req_port), .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM),
        .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTLOCKM(HMASTLOCKM),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic set_addr(input logic sel, input logic [1:0] trans, input logic [31:0] a,
                            input logic [2:0] burst, input logic lock);
        HSELS = sel; HTRANSS = trans; HADDRS = a; HBURSTS = burst; HMASTLOCKS = lock;
        HWRITES = 1'b1; HSIZES = 3'b010; HPROTS = 4'b0011;
    endtask

    task automatic set_slv(input logic g, input logic r, input logic e);
        addr_grant = g; HREADYM = r; HRESPM = e;
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        set_addr(1'b0, T_IDLE, 32'h0, B_SINGLE, 1'b0);
        set_slv(1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;
        set_addr(1'b1, T_IDLE, 32'h0, B_SINGLE, 1'b0);
        @(negedge HCLK);
        n_checks++; if (HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL rst_hready: got %b want 1", HREADYOUTS); end
        n_checks++; if (HRESPS !== 1'b0) begin n_fail++; $display("FAIL rst_hresp: got %b want 0", HRESPS); end
        n_checks++; if (req_port !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", req_port); end
        n_checks++; if (HTRANSM !== T_IDLE) begin n_fail++; $display("FAIL rst_htrans: got %b want 00", HTRANSM); end
        $display("txn reset done");
        next_cycle();
    endtask

    task automatic test_immediate_grant();
        set_addr(1'b1, T_NSEQ, 32'h1000, B_SINGLE, 1'b0);
        set_slv(1'b1, 1'b1, 1'b0);
        @(negedge HCLK);
        n_checks++; if (HADDRM !== 32'h1000) begin n_fail++; $display("FAIL imm_haddr: got %h want 00001000", HADDRM); end
        n_checks++; if (HTRANSM !== T_NSEQ) begin n_fail++; $display("FAIL imm_htrans: got %b want 10", HTRANSM); end
        n_checks++; if (HWRITEM !== 1'b1) begin n_fail++; $display("FAIL imm_hwrite: got %b want 1", HWRITEM); end
        n_checks++; if (req_port !== 1'b1) begin n_fail++; $display("FAIL imm_req: got %b want 1", req_port); end
        $display("txn immediate NONSEQ 0x1000");
        next_cycle();
        set_addr(1'b1, T_IDLE, 32'h1004, B_SINGLE, 1'b0);
        set_slv(1'b0, 1'b0, 1'b0);
        @(negedge HCLK);
        n_checks++; if (HREADYOUTS !== 1'b0) begin n_fail++; $display("FAIL imm_data_rdy0: got %b want 0", HREADYOUTS); end
        n_checks++; if (req_port !== 1'b0) begin n_fail++; $display("FAIL imm_req_idle: got %b want 0", req_port); end
        HREADYM = 1'b1;
        #1;
        n_checks++; if (HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL imm_data_rdy1: got %b want 1", HREADYOUTS); end
        next_cycle();
        HREADYM = 1'b0;
        @(negedge HCLK);
        n_checks++; if (HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL imm_after: got %b want 1", HREADYOUTS); end
        next_cycle();
    endtask

    task automatic test_delayed_grant();
        set_addr(1'b1, T_NSEQ, 32'h2000, B_INCR, 1'b1);
        set_slv(1'b0, 1'b1, 1'b0);
        @(negedge HCLK);
        n_checks++; if (HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL dly_c0_rdy: got %b want 1", HREADYOUTS); end
        n_checks++; if (req_port !== 1'b1) begin n_fail++; $display("FAIL dly_c0_req: got %b want 1", req_port); end
        $display("txn delayed NONSEQ 0x2000 offered");
        next_cycle();
        for (int i = 1; i <= 3; i++) begin
            set_addr(1'b1, T_NSEQ, 32'h2004, B_SINGLE, 1'b0);
            set_slv(i == 3, 1'b1, 1'b0);
            @(negedge HCLK);
            n_checks++; if (HREADYOUTS !== 1'b0) begin n_fail++; $display("FAIL dly_c%0d_rdy: got %b want 0", i, HREADYOUTS); end
            n_checks++; if (HADDRM !== 32'h2000) begin n_fail++; $display("FAIL dly_c%0d_haddr: got %h want 00002000", i, HADDRM); end
            n_checks++; if (HMASTLOCKM !== 1'b1) begin n_fail++; $display("FAIL dly_c%0d_lock: got %b want 1", i, HMASTLOCKM); end
            n_checks++; if (HBURSTM !== B_INCR) begin n_fail++; $display("FAIL dly_c%0d_burst: got %0d want 1", i, HBURSTM); end
            n_checks++; if (req_port !== 1'b1) begin n_fail++; $display("FAIL dly_c%0d_req: got %b want 1", i, req_port); end
            next_cycle();
        end
        set_addr(1'b1, T_IDLE, 32'h2004, B_SINGLE, 1'b0);
        set_slv(1'b0, 1'b1, 1'b0);
        @(negedge HCLK);
        n_checks++; if (HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL dly_c4_rdy: got %b want 1", HREADYOUTS); end
        n_checks++; if (req_port !== 1'b0) begin n_fail++; $display("FAIL dly_c4_req: got %b want 0", req_port); end
        n_checks++; if (HADDRM !== 32'h2004) begin n_fail++; $display("FAIL dly_c4_haddr: got %h want 00002004", HADDRM); end
        $display("txn delayed NONSEQ 0x2000 issued");
        next_cycle();
    endtask

    task automatic test_wait_states();
        set_addr(1'b1, T_NSEQ, 32'h3000, B_SINGLE, 1'b0);
        set_slv(1'b1, 1'b1, 1'b0);
        next_cycle();
        for (int i = 1; i <= 4; i++) begin
            set_addr(1'b1, T_IDLE, 32'h0, B_SINGLE, 1'b0);
            set_slv(1'b0, (i >= 3), 1'b0);
            @(negedge HCLK);
            n_checks++;
            if (HREADYOUTS !== (i >= 3)) begin
                n_fail++; $display("FAIL wait_c%0d_rdy: got %b want %b", i, HREADYOUTS, (i >= 3));
            end
            next_cycle();
        end
        $display("txn wait-state NONSEQ 0x3000");
    endtask

    task automatic test_error();
        set_addr(1'b1, T_NSEQ, 32'h4000, B_SINGLE, 1'b0);
        set_slv(1'b1, 1'b1, 1'b0);
        next_cycle();
        set_addr(1'b1, T_IDLE, 32'h0, B_SINGLE, 1'b0);
        set_slv(1'b0, 1'b0, 1'b1);
        @(negedge HCLK);
        n_checks++; if (HRESPS !== 1'b1) begin n_fail++; $display("FAIL err_c1_resp: got %b want 1", HRESPS); end
        n_checks++; if (HREADYOUTS !== 1'b0) begin n_fail++; $display("FAIL err_c1_rdy: got %b want 0", HREADYOUTS); end
        next_cycle();
        set_slv(1'b0, 1'b1, 1'b1);
        @(negedge HCLK);
        n_checks++; if (HRESPS !== 1'b1) begin n_fail++; $display("FAIL err_c2_resp: got %b want 1", HRESPS); end
        n_checks++; if (HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL err_c2_rdy: got %b want 1", HREADYOUTS); end
        next_cycle();
        set_slv(1'b0, 1'b1, 1'b1);
        @(negedge HCLK);
        n_checks++; if (HRESPS !== 1'b0) begin n_fail++; $display("FAIL err_c3_resp: got %b want 0", HRESPS); end
        $display("txn error NONSEQ 0x4000");
        next_cycle();
        HRESPM = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  tr [4];
        logic [31:0] ad [4];
        tr = '{T_NSEQ, T_SEQ, T_SEQ, T_SEQ};
        ad = '{32'h5000, 32'h5004, 32'h5008, 32'h500C};
        for (int i = 0; i < 4; i++) begin
            set_addr(1'b1, tr[i], ad[i], B_INCR4, 1'b0);
            set_slv(1'b1, 1'b1, 1'b0);
            @(negedge HCLK);
            n_checks++; if (HTRANSM !== tr[i]) begin n_fail++; $display("FAIL b2b_%0d_htrans: got %b want %b", i, HTRANSM, tr[i]); end
            n_checks++; if (HADDRM !== ad[i]) begin n_fail++; $display("FAIL b2b_%0d_haddr: got %h want %h", i, HADDRM, ad[i]); end
            n_checks++; if (HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL b2b_%0d_rdy: got %b want 1", i, HREADYOUTS); end
            n_checks++; if (HBURSTM !== B_INCR4) begin n_fail++; $display("FAIL b2b_%0d_burst: got %0d want 3", i, HBURSTM); end
            $display("txn INCR4 beat %0d addr %h", i, ad[i]);
            next_cycle();
        end
        set_addr(1'b1, T_IDLE, 32'h0, B_SINGLE, 1'b0);
        set_slv(1'b0, 1'b0, 1'b0);
        @(negedge HCLK);
        n_checks++; if (HREADYOUTS !== 1'b0) begin n_fail++; $display("FAIL b2b_last_data: got %b want 0", HREADYOUTS); end
        HREADYM = 1'b1;
        next_cycle();
    endtask

    task automatic test_busy_unselected();
        set_addr(1'b1, T_BUSY, 32'h7000, B_INCR, 1'b0);
        set_slv(1'b0, 1'b1, 1'b0);
        @(negedge HCLK);
        n_checks++; if (HTRANSM !== T_BUSY) begin n_fail++; $display("FAIL busy_htrans: got %b want 01", HTRANSM); end
        n_checks++; if (req_port !== 1'b0) begin n_fail++; $display("FAIL busy_req: got %b want 0", req_port); end
        next_cycle();
        set_addr(1'b0, T_NSEQ, 32'h7010, B_SINGLE, 1'b0);
        @(negedge HCLK);
        n_checks++; if (HTRANSM !== T_IDLE) begin n_fail++; $display("FAIL unsel_htrans: got %b want 00", HTRANSM); end
        n_checks++; if (req_port !== 1'b0) begin n_fail++; $display("FAIL unsel_req: got %b want 0", req_port); end
        n_checks++; if (HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL busy_nopend: got %b want 1", HREADYOUTS); end
        next_cycle();
        set_addr(1'b1, T_IDLE, 32'h0, B_SINGLE, 1'b0);
        @(negedge HCLK);
        n_checks++; if (HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL unsel_nopend: got %b want 1", HREADYOUTS); end
        $display("txn BUSY and unselected NONSEQ");
        next_cycle();
    endtask

    task automatic test_reset_mid_pend();
        set_addr(1'b1, T_NSEQ, 32'h6000, B_SINGLE, 1'b0);
        set_slv(1'b0, 1'b1, 1'b0);
        next_cycle();
        set_addr(1'b1, T_IDLE, 32'h0, B_SINGLE, 1'b0);
        @(negedge HCLK);
        n_checks++; if (HREADYOUTS !== 1'b0) begin n_fail++; $display("FAIL rstp_pend_rdy: got %b want 0", HREADYOUTS); end
        n_checks++; if (req_port !== 1'b1) begin n_fail++; $display("FAIL rstp_pend_req: got %b want 1", req_port); end
        HRESET = 1'b1;
        next_cycle();
        HRESET = 1'b0;
        @(negedge HCLK);
        n_checks++; if (req_port !== 1'b0) begin n_fail++; $display("FAIL rstp_req: got %b want 0", req_port); end
        n_checks++; if (HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL rstp_rdy: got %b want 1", HREADYOUTS); end
        n_checks++; if (HTRANSM !== T_IDLE) begin n_fail++; $display("FAIL rstp_htrans: got %b want 00", HTRANSM); end
        $display("txn reset during pending NONSEQ 0x6000");
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_immediate_grant();
        test_delayed_grant();
        test_wait_states();
        test_error();
        test_back_to_back();
        test_busy_unselected();
        test_reset_mid_pend();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
